// File: rtl/packer_pkg.sv
// Shared defaults and a lane-offset helper for the packer.
package packer_pkg;

  localparam int DefUnpackedWidth = 2;
  localparam int DefPackedNum     = 4;

  // Bit offset of lane `lane` when every lane is `width` bits wide.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/packer.sv
// Collects UnpackedWidth-bit elements LSB-lane-first into PackedWidth-bit
// words; last_i force-completes a partially filled word.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. valid_o is never retracted and packed_o/count_o stay
// stable while valid_o && !ready_i. ready_o depends only on output state and
// ready_i, never on valid_i.
module packer
  import packer_pkg::*;
#(
  parameter int UnpackedWidth = DefUnpackedWidth,
  parameter int PackedNum     = DefPackedNum,
  parameter int PackedWidth   = UnpackedWidth * PackedNum
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [UnpackedWidth-1:0]           unpacked_i,
  input  logic                               valid_i,
  input  logic                               last_i,
  output logic                               ready_o,
  output logic [PackedWidth-1:0]             packed_o,
  output logic [$clog2(PackedNum+1)-1:0]     count_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               done_o
);

  localparam int CountWidth   = $clog2(PackedNum);
  localparam int LaneCntWidth = $clog2(PackedNum + 1);

  if (PackedNum < 2) begin : g_bad_packed_num
    $error("packer: PackedNum must be at least 2");
  end
  if (PackedWidth != UnpackedWidth * PackedNum) begin : g_bad_packed_width
    $error("packer: PackedWidth must equal UnpackedWidth*PackedNum");
  end

  logic [PackedWidth-1:0]  acc_q;
  logic [CountWidth-1:0]   lane_q;
  logic [PackedWidth-1:0]  out_q;
  logic [LaneCntWidth-1:0] cnt_q;
  logic                    valid_q;

  logic                    in_fire;
  logic                    out_fire;
  logic                    complete;
  logic [PackedWidth-1:0]  merged;
  logic [LaneCntWidth-1:0] cnt_d;

  assign ready_o  = !valid_q || ready_i;
  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_q && ready_i;
  assign complete = in_fire && ((lane_q == CountWidth'(PackedNum - 1)) || last_i);
  assign cnt_d    = LaneCntWidth'(lane_q) + LaneCntWidth'(1);

  assign valid_o  = valid_q;
  assign packed_o = valid_q ? out_q : '0;
  assign count_o  = valid_q ? cnt_q : '0;
  assign done_o   = complete;

  // Accumulator with the incoming element written into the current lane.
  // Lanes above lane_q are still zero because acc_q clears on every completion.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < PackedNum; k++) begin
      if (lane_q == CountWidth'(k)) begin
        merged[lane_lsb(k, UnpackedWidth) +: UnpackedWidth] = unpacked_i;
      end
    end
  end

  // Accumulator and lane index: advance per accepted element, clear on completion.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else if (in_fire) begin
      if (complete) begin
        acc_q  <= '0;
        lane_q <= '0;
      end else begin
        acc_q  <= merged;
        lane_q <= lane_q + CountWidth'(1);
      end
    end
  end

  // Output word register: load on completion (even while draining), drop on drain.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (complete) begin
      out_q   <= merged;
      cnt_q   <= cnt_d;
      valid_q <= 1'b1;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_packer.sv
// Directed bench for packer (UnpackedWidth=2, PackedNum=4).
module tb_packer;

  logic       clk_i;
  logic       rst_i;
  logic [1:0] unpacked_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic [7:0] packed_o;
  logic [2:0] count_o;
  logic       valid_o;
  logic       ready_i;
  logic       done_o;

  packer #(.UnpackedWidth(2), .PackedNum(4), .PackedWidth(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .unpacked_i (unpacked_i),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .ready_o    (ready_o),
    .packed_o   (packed_o),
    .count_o    (count_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .done_o     (done_o)
  );

  // Clock / reset.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Directed table: inputs for one cycle, combinational expectations during the
  // cycle, registered expectations after the edge.
  typedef struct {
    logic       v;
    logic [1:0] d;
    logic       l;
    logic       r;
    logic       e_rdy;
    logic       e_done;
    logic       e_vo;
    logic [7:0] e_pk;
    logic [2:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic l, input logic r,
                              input logic e_rdy, input logic e_done,
                              input logic e_vo, input logic [7:0] e_pk, input logic [2:0] e_cnt);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.e_rdy = e_rdy; t.e_done = e_done;
    t.e_vo = e_vo; t.e_pk = e_pk; t.e_cnt = e_cnt;
    return t;
  endfunction

  // Scoreboard model state: expected words as {count, word}.
  logic [10:0] exp_q[$];
  logic [7:0]  m_acc;
  int          m_lane;
  logic        m_valid;
  logic        prev_hold;
  logic [7:0]  prev_packed;
  logic [2:0]  prev_count;

  task automatic model_reset();
    exp_q.delete();
    m_acc = '0; m_lane = 0; m_valid = 1'b0; prev_hold = 1'b0;
    prev_packed = '0; prev_count = '0;
  endtask

  // Driver with model-based checking; called and returns at the falling edge.
  task automatic sb_step(input logic v, input logic [1:0] d, input logic l, input logic r);
    logic       exp_rdy, in_f, out_f, comp;
    logic [10:0] w;
    valid_i = v; unpacked_i = d; last_i = l; ready_i = r;
    #1;
    exp_rdy = !m_valid || r;
    chk("ready_o", ready_o, exp_rdy);
    if (prev_hold) begin
      chk("valid_held", valid_o, 1'b1);
      chk("packed_stable", packed_o, prev_packed);
      chk("count_stable", count_o, prev_count);
    end
    out_f = m_valid && r;
    if (out_f) begin
      chk("valid_o_at_fire", valid_o, 1'b1);
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        chk("word_packed", packed_o, w[7:0]);
        chk("word_count", count_o, w[10:8]);
      end
    end
    in_f = v && exp_rdy;
    comp = in_f && ((m_lane == 3) || l);
    chk("done_o", done_o, comp);
    prev_hold   = m_valid && !r;
    prev_packed = packed_o;
    prev_count  = count_o;
    if (in_f) begin
      m_acc[m_lane*2 +: 2] = d;
      if (comp) begin
        exp_q.push_back({3'(m_lane + 1), m_acc});
        m_acc  = '0;
        m_lane = 0;
      end else begin
        m_lane++;
      end
    end
    if (comp) m_valid = 1'b1;
    else if (out_f) m_valid = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid_o"}, valid_o, 1'b0);
    chk({tag, "_packed_o"}, packed_o, 8'h00);
    chk({tag, "_count_o"}, count_o, 3'd0);
    chk({tag, "_done_o"}, done_o, 1'b0);
    chk({tag, "_ready_o"}, ready_o, 1'b1);
  endtask

  vec_t vecs[19];

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; unpacked_i = '0; ready_i = 1'b1;
    #2;
    chk_idle_outputs("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Full word, partial flush, restart at lane 0, back-pressure, empty flush,
    // last_i on the final lane.
    vecs[0]  = mk(1, 2'd1, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[1]  = mk(1, 2'd2, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[2]  = mk(1, 2'd3, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[3]  = mk(1, 2'd0, 0, 1,  1, 1,  1, 8'h39, 3'd4);
    vecs[4]  = mk(1, 2'd3, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[5]  = mk(1, 2'd1, 1, 1,  1, 1,  1, 8'h07, 3'd2);
    vecs[6]  = mk(1, 2'd2, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[7]  = mk(1, 2'd2, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[8]  = mk(1, 2'd2, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[9]  = mk(1, 2'd2, 0, 1,  1, 1,  1, 8'hAA, 3'd4);
    vecs[10] = mk(0, 2'd0, 0, 0,  0, 0,  1, 8'hAA, 3'd4);
    vecs[11] = mk(1, 2'd1, 1, 0,  0, 0,  1, 8'hAA, 3'd4);
    vecs[12] = mk(0, 2'd0, 1, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[13] = mk(0, 2'd3, 1, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[14] = mk(1, 2'd0, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[15] = mk(1, 2'd0, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[16] = mk(1, 2'd0, 0, 1,  1, 0,  0, 8'h00, 3'd0);
    vecs[17] = mk(1, 2'd3, 1, 1,  1, 1,  1, 8'hC0, 3'd4);
    vecs[18] = mk(0, 2'd0, 0, 1,  1, 0,  0, 8'h00, 3'd0);

    @(negedge clk_i);
    foreach (vecs[i]) begin
      valid_i = vecs[i].v; unpacked_i = vecs[i].d; last_i = vecs[i].l; ready_i = vecs[i].r;
      #1;
      chk($sformatf("v%0d_ready_o", i), ready_o, vecs[i].e_rdy);
      chk($sformatf("v%0d_done_o", i), done_o, vecs[i].e_done);
      @(posedge clk_i);
      @(negedge clk_i);
      chk($sformatf("v%0d_valid_o", i), valid_o, vecs[i].e_vo);
      chk($sformatf("v%0d_packed_o", i), packed_o, vecs[i].e_pk);
      chk($sformatf("v%0d_count_o", i), count_o, vecs[i].e_cnt);
    end

    // Back-pressure: hold 0x55 for 5 cycles while an element waits, then drain
    // and accept in the same cycle; the following word proves nothing was lost.
    model_reset();
    for (int i = 0; i < 4; i++) sb_step(1'b1, 2'd1, 1'b0, 1'b1);
    chk("bp_word_valid", valid_o, 1'b1);
    chk("bp_word_packed", packed_o, 8'h55);
    for (int i = 0; i < 5; i++) begin
      sb_step(1'b1, 2'd2, 1'b0, 1'b0);
      chk("bp_ready_low", ready_o, 1'b0);
    end
    sb_step(1'b1, 2'd2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) sb_step(1'b1, 2'd2, 1'b0, 1'b1);
    chk("bp_next_packed", packed_o, 8'hAA);
    sb_step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Streaming: 64 random elements back to back -> 16 words.
    begin
      int words = 0;
      for (int i = 0; i < 64; i++) begin
        sb_step(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        if (valid_o) words++;
      end
      sb_step(1'b0, 2'd0, 1'b0, 1'b1);
      chk("stream_words", words, 16);
      chk("stream_sb_empty", exp_q.size(), 0);
    end

    // Reset with a held word, then reset mid-word, then a clean word.
    for (int i = 0; i < 4; i++) sb_step(1'b1, 2'd2, 1'b0, 1'b0);
    chk("rst_held_valid", valid_o, 1'b1);
    valid_i = 1'b0; last_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 chk_idle_outputs("rst_held");
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    sb_step(1'b1, 2'd3, 1'b0, 1'b1);
    sb_step(1'b1, 2'd3, 1'b0, 1'b1);
    #2 rst_i = 1'b0;
    #1 chk_idle_outputs("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) sb_step(1'b1, 2'd1, 1'b0, 1'b1);
    chk("rst_clean_packed", packed_o, 8'h55);
    chk("rst_clean_count", count_o, 3'd4);
    sb_step(1'b0, 2'd0, 1'b0, 1'b1);

    // Random valid/ready/last toggling against the model.
    for (int i = 0; i < 300; i++) begin
      sb_step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) sb_step(1'b0, 2'd0, 1'b0, 1'b1);
    chk("rand_sb_empty", exp_q.size(), 0);
    chk("rand_final_valid", valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
